// File: rtl/sysid_checker_if.sv
// ---------------------------------------------------------------------------
// sysid_checker_if
//   Avalon-MM read-only bus between sysid_checker (master) and a system-ID
//   slave.
//
//   address        master -> slave  word address (0 = ID, 1 = timestamp)
//   read           master -> slave  read request
//   readdata       slave  -> master read data, valid with readdatavalid
//   waitrequest    slave  -> master stall; command accepted when read=1 and
//                                   waitrequest=0
//   readdatavalid  slave  -> master readdata carries the response this cycle
// ---------------------------------------------------------------------------
interface sysid_checker_if;
    logic        address;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        readdatavalid;

    modport master (
        output address, read,
        input  readdata, waitrequest, readdatavalid
    );

    modport slave (
        input  address, read,
        output readdata, waitrequest, readdatavalid
    );
endinterface

// File: rtl/sysid_checker.sv
// ---------------------------------------------------------------------------
// sysid_checker
//   Boot-time sanity check: on a start pulse, reads the system-ID slave's
//   ID word (address 0) and timestamp word (address 1) over Avalon-MM and
//   compares both against build-time constants.
//
//   Optional feature macro: SYSID_CHK_TIMEOUT_EN
//     defined   -> each read aborts after TIMEOUT_CYCLES cycles without
//                  readdatavalid; o_timeout reports the abort.
//     undefined -> reads wait indefinitely; o_timeout is tied to 0.
//
//   Ports
//     i_clk        clock, all logic on rising edge
//     i_rst        asynchronous active-high reset
//     i_start      one-cycle request; ignored while busy
//     o_busy       high from the cycle after an accepted start through done
//     o_done       one-cycle pulse when a check completes or aborts
//     o_id_ok      captured ID == EXPECTED_ID (held until next done)
//     o_ts_ok      captured timestamp == EXPECTED_TS (held until next done)
//     o_timeout    last check aborted on timeout (held until next done)
//     o_id_value   last captured ID word
//     o_ts_value   last captured timestamp word
//     avm          Avalon-MM master port (sysid_checker_if.master)
// ---------------------------------------------------------------------------
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_id_ok,
    output logic            o_ts_ok,
    output logic            o_timeout,
    output logic [31:0]     o_id_value,
    output logic [31:0]     o_ts_value,
    sysid_checker_if.master avm
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        WAIT_ID,
        RD_TS,
        WAIT_TS,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_abort;

    logic        r_read;
    logic        r_address;
    logic        r_busy;
    logic        r_done;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

`ifdef SYSID_CHK_TIMEOUT_EN
    localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_cnt;
    logic        r_timeout;
    logic        w_active;
    logic        w_rd_entry;

    assign w_active   = r_state inside {RD_ID, WAIT_ID, RD_TS, WAIT_TS};
    assign w_rd_entry = (w_next == RD_ID && r_state != RD_ID) ||
                        (w_next == RD_TS && r_state != RD_TS);

    // The limit is the TIMEOUT_CYCLES-th cycle of a read. A response landing
    // in that same cycle still wins over the abort.
    assign w_abort = w_active && (r_cnt == CNT_LIMIT) &&
                     !((r_state inside {WAIT_ID, WAIT_TS}) && avm.readdatavalid);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_rd_entry) begin
                r_cnt <= '0;
            end else if (w_active) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_next == DONE) begin
                r_timeout <= w_abort;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_abort   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    // NOTE: w_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_next = RD_ID;
            RD_ID: begin
                if (w_abort)               w_next = DONE;
                else if (!avm.waitrequest) w_next = WAIT_ID;
            end
            WAIT_ID: begin
                if (avm.readdatavalid)     w_next = RD_TS;
                else if (w_abort)          w_next = DONE;
            end
            RD_TS: begin
                if (w_abort)               w_next = DONE;
                else if (!avm.waitrequest) w_next = WAIT_TS;
            end
            WAIT_TS: begin
                if (avm.readdatavalid)     w_next = DONE;
                else if (w_abort)          w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Registered outputs, computed from the state being entered so they line
    // up with the state itself.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_read     <= 1'b0;
            r_address  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
        end else begin
            r_read <= (w_next == RD_ID) || (w_next == RD_TS);
            r_busy <= (w_next != IDLE);
            r_done <= (w_next == DONE);

            if (w_next == RD_ID) begin
                r_address <= 1'b0;
            end else if (w_next == RD_TS) begin
                r_address <= 1'b1;
            end

            // Responses are only taken while waiting for one; stray or late
            // readdatavalid elsewhere is dropped.
            if (r_state == WAIT_ID && avm.readdatavalid) begin
                r_id_value <= avm.readdata;
            end
            if (r_state == WAIT_TS && avm.readdatavalid) begin
                r_ts_value <= avm.readdata;
            end

            // On a normal completion the timestamp is arriving on this very
            // edge, so it is compared straight from the bus.
            if (w_next == DONE) begin
                r_id_ok <= !w_abort && (r_id_value == EXPECTED_ID);
                r_ts_ok <= !w_abort && (avm.readdata == EXPECTED_TS);
            end
        end
    end

    assign avm.read    = r_read;
    assign avm.address = r_address;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_id_ok     = r_id_ok;
    assign o_ts_ok     = r_ts_ok;
    assign o_id_value  = r_id_value;
    assign o_ts_value  = r_ts_value;

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Avalon-MM read master that queries a system-ID slave and checks the returned values. On a start pulse it reads word 0 (ID) and then word 1 (timestamp), compares both against build-time constants and reports pass/fail flags. It sits beside the Nios/SoC interconnect as a hardware boot-time sanity check: the bitstream and software build must agree.

## Interface

- EXPECTED_ID, 32'd0: value the ID word (address 0) must return.
- EXPECTED_TS, 32'd0: value the timestamp word (address 1) must return.
- TIMEOUT_CYCLES, 255: per-read response limit in cycles (1..65535); used only when the timeout feature is compiled in.
- clock  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a check; ignored while busy.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse when a check completes or aborts.
- id_ok  out  1  captured ID == EXPECTED_ID; valid from done and held until the next done.
- ts_ok  out  1  captured timestamp == EXPECTED_TS; same validity as id_ok.
- timeout  out  1  the last check aborted on a timeout; same validity as id_ok.
- id_value  out  32  last captured ID word.
- ts_value  out  32  last captured timestamp word.
- address  out  1  Avalon word address (0 = ID, 1 = timestamp).
- read  out  1  Avalon read request.
- readdata  in  32  Avalon read data.
- waitrequest  in  1  slave stall; the command is accepted on a cycle with read=1 and waitrequest=0.
- readdatavalid  in  1  readdata is valid this cycle.

## Operation

- FSM states: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE. All outputs are registered.
- IDLE: start=1 -> RD_ID. The flags and captured values are held.
- RD_ID: read=1, address=0. An accept -> WAIT_ID; read drops on the next cycle. Address and read stay stable while waitrequest=1.
- WAIT_ID: read=0. readdatavalid=1 -> capture id_value -> RD_TS.
- RD_TS and WAIT_TS: the same as RD_ID and WAIT_ID, with address=1; capture into ts_value -> DONE.
- DONE: done=1 for one cycle. id_ok, ts_ok and timeout update on the edge entering DONE. Next state is IDLE.
- Only one outstanding read at a time; the block never pipelines reads.
- readdatavalid outside WAIT_ID and WAIT_TS is ignored, including late data after an abort.
- A start pulse while busy=1 is dropped; it is not queued.
- Reset asserted mid-check: IDLE immediately and asynchronously. read, done and busy go low at once; in-flight data is discarded.
- Reset values: address=0, read=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0.
- The comparisons are a full 32-bit equality. There is no masking.

## Timing

- start is sampled in cycle 0 -> RD_ID in cycle 1.
- Zero-wait slave with readdatavalid one cycle after accept:
  - ID accepted in cycle 1; data in cycle 2.
  - RD_TS in cycle 3; data in cycle 4.
  - done=1 in cycle 5; IDLE in cycle 6.
  - A new start is accepted in cycle 6 at the earliest.
- Each waitrequest cycle and each extra response-latency cycle adds exactly one cycle.
- busy=1 in cycles 1..5.

## Configuration

- SYSID_CHK_TIMEOUT_EN defined:
  - A counter clears on entry to RD_ID and on entry to RD_TS, and increments every cycle in RD_* and WAIT_*.
  - The counter reaching TIMEOUT_CYCLES with no readdatavalid -> DONE with timeout=1, id_ok=0, ts_ok=0. read drops in the DONE cycle.
  - Captured values keep whatever was received before the abort.
  - Data arriving in the same cycle the limit is reached wins: no timeout.
- Not defined: the block waits indefinitely. timeout is tied to 0, and the counter is not built.

## Test plan

- EXPECTED_ID=32'h5622F56B, EXPECTED_TS=0. Slave returns 32'h5622F56B for address 1'b0 and 0 for address 1'b1, zero wait -> done in cycle 5 with id_ok=1, ts_ok=1, timeout=0, id_value=32'h5622F56B.
- Slave returns ID 32'h5622F56A -> id_ok=0, ts_ok=1, id_value=32'h5622F56A.
- waitrequest high for 3 cycles on each read, and readdatavalid 2 cycles after accept -> address and read are stable while stalled, and done arrives in cycle 13.
- Second start pulse in cycle 2 of a check -> exactly one done pulse, and busy stays high without interruption.
- With SYSID_CHK_TIMEOUT_EN and TIMEOUT_CYCLES=8, the slave never asserts readdatavalid for address 1 -> done with timeout=1, id_ok=0, ts_ok=0. A late readdatavalid is then ignored.
- reset pulsed while in WAIT_TS -> read=0, busy=0 and all flags 0 immediately. A following start completes a normal check.
